bfloat_sub_sched: RTL and testbench

BFLOAT_SUB_SCHED -- requirements
Module: bfloat_sub_sched

---
 rtl/bfloat_sub_sched.sv | 113 +++++++++++
 tb/tb_bfloat_sub_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat_sub_sched.sv
// bfloat_sub_sched: round-robin scheduler sharing one combinational bfloat16 subtractor between two requesters
module bfloat_sub_sched #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_c,
    output logic        rsp_id,
    output logic [15:0] dp_a,
    output logic [15:0] dp_b,
    input  logic [15:0] dp_c,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic [15:0] dp_a_q, dp_a_d;
    logic [15:0] dp_b_q, dp_b_d;
    logic [15:0] rsp_c_q, rsp_c_d;
    logic        rsp_id_q, rsp_id_d;
    logic        g0, g1;
    logic [15:0] sel_a, sel_b;
    logic        sel_op;

    // Round-robin: on contention the requester not granted last wins
    assign g0 = req0_valid & (~req1_valid | ptr_q);
    assign g1 = req1_valid & (~req0_valid | ~ptr_q);

    assign sel_a  = g1 ? req1_a : req0_a;
    assign sel_b  = g1 ? req1_b : req0_b;
    assign sel_op = g1 ? req1_op : req0_op;

    assign req0_ready = rst_n & (state_q == IDLE) & g0;
    assign req1_ready = rst_n & (state_q == IDLE) & g1;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_c      = rsp_c_q;
    assign rsp_id     = rsp_id_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;

    // Next-state: capture operands on accept, count LAT stable cycles, hold result until drained
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        rsp_c_d  = rsp_c_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (g0 || g1) begin
                    dp_a_d   = sel_a;
                    dp_b_d   = {sel_b[15] ^ sel_op, sel_b[14:0]};
                    rsp_id_d = g1;
                    ptr_d    = g1;
                    cnt_d    = 4'd0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_M1) begin
                    rsp_c_d = dp_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ptr_q    <= 1'b1;
            dp_a_q   <= 16'h0;
            dp_b_q   <= 16'h0;
            rsp_c_q  <= 16'h0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            dp_a_q   <= dp_a_d;
            dp_b_q   <= dp_b_d;
            rsp_c_q  <= rsp_c_d;
            rsp_id_q <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_bfloat_sub_sched.sv
// tb_bfloat_sub_sched: directed checks of the bfloat subtract scheduler at LAT 2, 1 and 15
module tb_bfloat_sub_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_op = 1'b0, req1_op = 1'b0;
    logic        rdy0 [3];
    logic        rdy1 [3];
    logic        rv   [3];
    logic        rid  [3];
    logic        bz   [3];
    logic [15:0] rc   [3];
    logic [15:0] da   [3];
    logic [15:0] db   [3];
    logic [15:0] dc   [3];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // index 0: LAT=2, index 1: LAT=1, index 2: LAT=15; all share the request inputs
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bfloat_sub_sched #(.LAT(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req0_valid), .req0_ready(rdy0[g]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
            .req1_valid(req1_valid), .req1_ready(rdy1[g]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_c(rc[g]), .rsp_id(rid[g]),
            .dp_a(da[g]), .dp_b(db[g]), .dp_c(dc[g]), .busy(bz[g])
        );
    end

    function automatic real bf2r(input logic [15:0] x);
        logic [10:0] e;
        if (x[14:7] == 8'd0) return 0.0;
        e = {3'b000, x[14:7]} + 11'd896;
        return $bitstoreal({x[15], e, x[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        bits = $realtobits(r);
        if (bits[62:0] == 63'd0) return 16'h0000;
        e = bits[62:52] - 11'd896;
        return {bits[63], e[7:0], bits[51:45]};
    endfunction

    // Shared subtractor model (exact for the chosen vectors, truncating otherwise)
    always_comb begin
        for (int i = 0; i < 3; i++) dc[i] = r2bf(bf2r(da[i]) - bf2r(db[i]));
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = 0;
        req1_a = '0; req1_b = '0; req1_op = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset;
        #3;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        rst_n = 0;
        #1;
        if (rdy0[0] !== 1'b0) begin $display("FAIL reset_rdy0: got %b expected 0", rdy0[0]); n_fail++; end n_chk++;
        if (rdy1[0] !== 1'b0) begin $display("FAIL reset_rdy1: got %b expected 0", rdy1[0]); n_fail++; end n_chk++;
        if (rv[0] !== 1'b0) begin $display("FAIL reset_rsp_valid: got %b expected 0", rv[0]); n_fail++; end n_chk++;
        if (bz[0] !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bz[0]); n_fail++; end n_chk++;
        if (rid[0] !== 1'b0) begin $display("FAIL reset_rsp_id: got %b expected 0", rid[0]); n_fail++; end n_chk++;
        if (rc[0] !== 16'h0) begin $display("FAIL reset_rsp_c: got %h expected 0000", rc[0]); n_fail++; end n_chk++;
        if (da[0] !== 16'h0) begin $display("FAIL reset_dp_a: got %h expected 0000", da[0]); n_fail++; end n_chk++;
        if (db[0] !== 16'h0) begin $display("FAIL reset_dp_b: got %h expected 0000", db[0]); n_fail++; end n_chk++;
        clear_inputs();
    endtask

    task automatic test_single_sub;
        do_reset();
        req0_a = 16'hC120; req0_b = 16'h4170; req0_op = 0; req0_valid = 1;
        #1;
        if (rdy0[0] !== 1'b1) begin $display("FAIL sub_rdy0: got %b expected 1", rdy0[0]); n_fail++; end n_chk++;
        if (rdy1[0] !== 1'b0) begin $display("FAIL sub_rdy1: got %b expected 0", rdy1[0]); n_fail++; end n_chk++;
        step();
        req0_valid = 0;
        if (bz[0] !== 1'b1) begin $display("FAIL sub_busy: got %b expected 1", bz[0]); n_fail++; end n_chk++;
        if (da[0] !== 16'hC120) begin $display("FAIL sub_dp_a: got %h expected c120", da[0]); n_fail++; end n_chk++;
        if (db[0] !== 16'h4170) begin $display("FAIL sub_dp_b: got %h expected 4170", db[0]); n_fail++; end n_chk++;
        if (rv[0] !== 1'b0) begin $display("FAIL sub_early1: got %b expected 0", rv[0]); n_fail++; end n_chk++;
        step();
        if (rv[0] !== 1'b0) begin $display("FAIL sub_early2: got %b expected 0", rv[0]); n_fail++; end n_chk++;
        step();
        if (rv[0] !== 1'b1) begin $display("FAIL sub_rsp_valid: got %b expected 1", rv[0]); n_fail++; end n_chk++;
        if (rc[0] !== 16'hC1C8) begin $display("FAIL sub_rsp_c: got %h expected c1c8", rc[0]); n_fail++; end n_chk++;
        if (rid[0] !== 1'b0) begin $display("FAIL sub_rsp_id: got %b expected 0", rid[0]); n_fail++; end n_chk++;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        if (rv[0] !== 1'b0) begin $display("FAIL sub_drain: got %b expected 0", rv[0]); n_fail++; end n_chk++;
    endtask

    task automatic test_single_add;
        do_reset();
        req1_a = 16'hC120; req1_b = 16'h4170; req1_op = 1; req1_valid = 1;
        #1;
        if (rdy1[0] !== 1'b1) begin $display("FAIL add_rdy1: got %b expected 1", rdy1[0]); n_fail++; end n_chk++;
        if (rdy0[0] !== 1'b0) begin $display("FAIL add_rdy0: got %b expected 0", rdy0[0]); n_fail++; end n_chk++;
        step();
        req1_valid = 0;
        if (db[0] !== 16'hC170) begin $display("FAIL add_dp_b: got %h expected c170", db[0]); n_fail++; end n_chk++;
        step();
        step();
        if (rv[0] !== 1'b1) begin $display("FAIL add_rsp_valid: got %b expected 1", rv[0]); n_fail++; end n_chk++;
        if (rc[0] !== 16'h40A0) begin $display("FAIL add_rsp_c: got %h expected 40a0", rc[0]); n_fail++; end n_chk++;
        if (rid[0] !== 1'b1) begin $display("FAIL add_rsp_id: got %b expected 1", rid[0]); n_fail++; end n_chk++;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_contention;
        int ids [3] = '{2, 2, 2};
        int cyc [3] = '{0, 0, 0};
        int n = 0;
        int both = 0;
        do_reset();
        req0_a = 16'h3F80; req0_b = 16'h3F00; req0_op = 0; req0_valid = 1;
        req1_a = 16'hC120; req1_b = 16'h4170; req1_op = 1; req1_valid = 1;
        rsp_ready = 1;
        for (int c = 0; c < 30 && n < 3; c++) begin
            #1;
            if (rdy0[0] && rdy1[0]) both++;
            if (rdy0[0]) begin ids[n] = 0; cyc[n] = c; n++; end
            else if (rdy1[0]) begin ids[n] = 1; cyc[n] = c; n++; end
            step();
        end
        clear_inputs();
        if (both != 0) begin $display("FAIL cont_both_ready: got %0d cycles expected 0", both); n_fail++; end n_chk++;
        if (n != 3) begin $display("FAIL cont_count: got %0d accepts expected 3", n); n_fail++; end n_chk++;
        if (ids[0] != 0 || ids[1] != 1 || ids[2] != 0) begin
            $display("FAIL cont_order: got %0d,%0d,%0d expected 0,1,0", ids[0], ids[1], ids[2]); n_fail++;
        end n_chk++;
        if (cyc[1] - cyc[0] != 4 || cyc[2] - cyc[1] != 4) begin
            $display("FAIL cont_spacing: got %0d,%0d expected 4,4", cyc[1] - cyc[0], cyc[2] - cyc[1]); n_fail++;
        end n_chk++;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        do_reset();
        req0_a = 16'h3F80; req0_b = 16'h3F00; req0_op = 0; req0_valid = 1;
        step();
        req0_valid = 0;
        step();
        step();
        req1_a = 16'h4040; req1_b = 16'h3F80; req1_op = 0; req1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rv[0] !== 1'b1 || rc[0] !== 16'h3F00 || rid[0] !== 1'b0 || rdy1[0] !== 1'b0) begin
                $display("FAIL bp_stall cycle %0d: got v=%b c=%h id=%b rdy1=%b expected 1 3f00 0 0", i, rv[0], rc[0], rid[0], rdy1[0]);
                bad++;
            end
            step();
        end
        if (bad != 0) n_fail++;
        n_chk++;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        if (rdy1[0] !== 1'b1) begin $display("FAIL bp_next_ready: got %b expected 1", rdy1[0]); n_fail++; end n_chk++;
        step();
        req1_valid = 0;
        if (da[0] !== 16'h4040) begin $display("FAIL bp_next_dp_a: got %h expected 4040", da[0]); n_fail++; end n_chk++;
        step();
        step();
        if (rv[0] !== 1'b1 || rc[0] !== 16'h4000 || rid[0] !== 1'b1) begin
            $display("FAIL bp_next_rsp: got v=%b c=%h id=%b expected 1 4000 1", rv[0], rc[0], rid[0]); n_fail++;
        end n_chk++;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int k = 0;
        do_reset();
        req1_a = 16'hC120; req1_b = 16'h4170; req1_op = 1; req1_valid = 1;
        step();
        req1_valid = 0;
        step();
        rst_n = 0;
        #1;
        if (bz[0] !== 1'b0) begin $display("FAIL mid_busy: got %b expected 0", bz[0]); n_fail++; end n_chk++;
        if (rid[0] !== 1'b0) begin $display("FAIL mid_rsp_id: got %b expected 0", rid[0]); n_fail++; end n_chk++;
        if (da[0] !== 16'h0 || db[0] !== 16'h0) begin
            $display("FAIL mid_dp: got %h %h expected 0000 0000", da[0], db[0]); n_fail++;
        end n_chk++;
        step();
        rst_n = 1;
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (rv[0] === 1'b1) seen++;
            step();
        end
        if (seen != 0) begin $display("FAIL mid_no_rsp: got %0d cycles valid expected 0", seen); n_fail++; end n_chk++;
        rsp_ready = 0;
        req0_a = 16'hC120; req0_b = 16'h4170; req0_op = 0; req0_valid = 1;
        step();
        req0_valid = 0;
        while (rv[0] !== 1'b1 && k < 20) begin step(); k++; end
        if (rv[0] !== 1'b1 || rc[0] !== 16'hC1C8 || rid[0] !== 1'b0) begin
            $display("FAIL mid_recover: got v=%b c=%h id=%b expected 1 c1c8 0", rv[0], rc[0], rid[0]); n_fail++;
        end n_chk++;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_lat;
        int rise [3] = '{0, 0, 0};
        int moved = 0;
        do_reset();
        req0_a = 16'h4040; req0_b = 16'h3F80; req0_op = 0; req0_valid = 1;
        step();
        req0_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (rv[i] === 1'b1 && rise[i] == 0) rise[i] = k;
                if (da[i] !== 16'h4040 || db[i] !== 16'h3F80) moved++;
            end
        end
        if (rise[0] != 2) begin $display("FAIL lat2_rise: got %0d expected 2", rise[0]); n_fail++; end n_chk++;
        if (rise[1] != 1) begin $display("FAIL lat1_rise: got %0d expected 1", rise[1]); n_fail++; end n_chk++;
        if (rise[2] != 15) begin $display("FAIL lat15_rise: got %0d expected 15", rise[2]); n_fail++; end n_chk++;
        if (moved != 0) begin $display("FAIL lat_dp_stable: got %0d changes expected 0", moved); n_fail++; end n_chk++;
        if (rc[1] !== 16'h4000 || rc[2] !== 16'h4000) begin
            $display("FAIL lat_rsp_c: got %h %h expected 4000 4000", rc[1], rc[2]); n_fail++;
        end n_chk++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_sub();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_lat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
